ysyx_22041412_ifu: RTL

YSYX_22041412_IFU -- requirements
Module: ysyx_22041412_ifu

---
 rtl/ysyx_22041412_ifu.sv | 113 +++++++++++
 1 files changed

// File: rtl/ysyx_22041412_ifu.sv
// ysyx_22041412_ifu: instruction fetch unit with credit-based request issue,
// an in-order instruction buffer and redirect handling that flushes in-flight fetches.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   imem_req_valid/ready/addr           fetch request handshake towards instruction memory
//   imem_resp_valid/data                in-order responses, no backpressure
//   redirect_valid/pc                   flow change from decode or execute
//   out_valid/ready/instr/pc            instruction stream towards decode
module ysyx_22041412_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] W_DEPTH = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t          r_state, w_next;
    logic [31:0]     r_pc;
    logic [CW-1:0]   r_out, r_drop, r_cnt;
    logic [PW-1:0]   r_head, r_tail;
    logic [31:0]     r_buf_pc    [DEPTH];
    logic [31:0]     r_buf_instr [DEPTH];

    logic            w_req_fire, w_resp_ok, w_push, w_pop;
    logic [CW:0]     w_used;
    logic [CW-1:0]   w_out_next;
    logic [31:0]     w_resp_pc;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_resp_ok      = imem_resp_valid && r_out != '0;
    assign w_used         = {1'b0, r_out} + {1'b0, r_cnt};
    assign imem_req_valid = r_state == RUN && !redirect_valid && w_used < W_DEPTH;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_push         = r_state == RUN && !redirect_valid && w_resp_ok;
    assign w_pop          = out_valid && out_ready;
    // On a redirect this is also the number of responses still to be discarded.
    assign w_out_next     = r_out + CW'(w_req_fire) - CW'(w_resp_ok);
    // pc already points past every outstanding request, so the oldest one is this far back.
    assign w_resp_pc      = r_pc - (32'(r_out) << 2);
    assign out_valid      = r_cnt != '0;
    assign out_instr      = out_valid ? r_buf_instr[r_head] : '0;
    assign out_pc         = out_valid ? r_buf_pc[r_head] : '0;

    always_comb begin
        w_next = r_state;
        if (redirect_valid)
            w_next = w_out_next == '0 ? RUN : FLUSH;
        else if (r_state == BOOT)
            w_next = RUN;
        else if (r_state == FLUSH && (r_drop == '0 || (w_resp_ok && r_drop == CW'(1))))
            w_next = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= BOOT;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= RESET_PC;
            r_out  <= '0;
            r_drop <= '0;
            r_cnt  <= '0;
            r_head <= '0;
            r_tail <= '0;
        end else if (redirect_valid) begin
            r_pc   <= redirect_pc & ~32'h3;
            r_out  <= w_out_next;
            r_drop <= w_out_next;
            r_cnt  <= '0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_req_fire)
                r_pc <= r_pc + 32'd4;
            r_out <= w_out_next;
            if (r_state == FLUSH && w_resp_ok && r_drop != '0)
                r_drop <= r_drop - CW'(1);
            if (w_push)
                r_tail <= r_tail == PW'(DEPTH - 1) ? '0 : r_tail + PW'(1);
            if (w_pop)
                r_head <= r_head == PW'(DEPTH - 1) ? '0 : r_head + PW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_tail]    <= w_resp_pc;
            r_buf_instr[r_tail] <= imem_resp_data;
        end
    end
endmodule
